conv_sequencer: RTL and testbench
=================================

Name: conv_sequencer

Overview:
- Control FSM that runs one full convolution layer on the 8x8 systolic core without testbench intervention.
- On start, it loops over every kernel position kij. For each one it reads weights from input SRAM into L0, loads them into the array, streams activations through L0 into the array, then drains the pipeline.
- It owns the core-side input SRAM port: i_cen, i_wen, i_a. The existing TB_CL_SELECT mux picks between this port and the testbench port.

Parameters:
row, 8, array rows (weight words per kij)
col, 8, array columns
len_kij, 9, kernel positions per layer
len_nij, 36, activation words per layer
W_BASE, 0, input SRAM address of weight word 0
A_BASE, 72, input SRAM address of activation word 0
ADDR_W, 7, input SRAM address width
LOAD_CYC, 16, array_load duration per kij (row+col)
DRAIN_CYC, 16, pipeline flush cycles per kij (row+col)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
start  in  1  level; begins a layer when sampled high in IDLE with tb_sel=0
tb_sel  in  1  testbench owns the SRAM (TB_CL_SELECT)
i_cen  out  1  input SRAM chip enable, active-low
i_wen  out  1  input SRAM write enable, active-low; always 1
i_a  out  ADDR_W  input SRAM address
l0_wr  out  1  L0 write; data = SRAM Q of the previous cycle
l0_rd  out  1  L0 read toward array
array_load  out  1  weight-load instruction to PE array
array_exec  out  1  execute instruction to PE array
ofifo_valid  in  1  output FIFO has a full row
ofifo_rd  out  1  pop output FIFO
kij_idx  out  4  current kernel position, 0..len_kij-1
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at layer completion

Behaviour:
- Reset values: state=IDLE, i_cen=1, i_wen=1, i_a=0, all other outputs 0, counters 0. A reset asserted mid-layer aborts on the next edge: no done pulse, no further SRAM reads. Reset has priority over start.
- All outputs except ofifo_rd are registered and valid for the cycle the FSM is in the named state/count. ofifo_rd = ofifo_valid & busy, combinational.
- Single counter cnt is cleared on every state change. kij advances only in DRAIN→RD_W.
- IDLE: if start & !tb_sel, go to RD_W with kij=0. start while busy is ignored. start held high after done starts a new layer on the cycle after done.
- RD_W (cnt 0..row-1):
  - i_cen=0; i_a = W_BASE + kij*row + cnt.
  - l0_wr is i_cen-read delayed 1 cycle, so the last l0_wr falls in LD_W cnt=0.
- LD_W (cnt 0..LOAD_CYC-1):
  - array_load=1 for all cycles.
  - l0_rd=1 for cnt 1..row. No l0_rd in the cycle of the last l0_wr.
- RD_A (cnt 0..len_nij-1):
  - i_cen=0; i_a = A_BASE + cnt.
  - l0_wr follows 1 cycle later; the last one falls in EXEC cnt=0.
- EXEC (cnt 0..len_nij-1): array_exec=1; l0_rd=1 for cnt 1..len_nij-1 plus DRAIN cnt=0, i.e. len_nij reads total.
- DRAIN (cnt 0..DRAIN_CYC-1): on the last cycle, if kij==len_kij-1 go to IDLE with done=1 on the next cycle; else go to RD_W with kij+1.
- Per-kij length = row+LOAD_CYC+2*len_nij+DRAIN_CYC = 112 cycles. The full layer is 1008 cycles from first RD_W to done.
- Address arithmetic: ADDR_W bits, no wrap expected. Maximum addresses are 71 (weights) and 107 (activations).
- tb_sel is checked only in IDLE. The integrator keeps tb_sel=0 while busy, and the block does not react to it then.
- i_wen is never driven low. The block never writes SRAM.

Test Plan:
- Reset then idle: reset=1 for 2 cycles → i_cen=1, i_a=0, busy=0, done=0; start with tb_sel=1 → stays IDLE.
- First kij weights: start=1 → i_a reads 0..7 on consecutive cycles with i_cen=0; l0_wr high 8 cycles, lagging i_cen by exactly 1.
- Sequence: at kij=3, RD_W addresses 24..31. Every kij has RD_A addresses 72..107. array_load high 16 cycles and array_exec high 36 cycles per kij; l0_wr count = l0_rd count = 44 per kij.
- Completion: done pulses exactly once, 1008 cycles after the first RD_W cycle. kij_idx reads 8 in the final DRAIN. busy falls with done.
- Reset mid-op: reset asserted in EXEC at kij=5 → next cycle IDLE, i_cen=1, no done. A fresh start restarts at kij=0, address 0.
- Output drain: ofifo_valid toggled randomly while busy → ofifo_rd mirrors it combinationally. With busy=0, ofifo_valid=1 → ofifo_rd=0.

Source files
------------

// File: rtl/conv_sequencer.sv
// Layer sequencer for the 8x8 systolic core. For every kernel position it reads
// the weights, loads them into the array, streams the activations, then drains.
module conv_sequencer #(
    parameter int row       = 8,
    parameter int col       = 8,
    parameter int len_kij   = 9,
    parameter int len_nij   = 36,
    parameter int W_BASE    = 0,
    parameter int A_BASE    = 72,
    parameter int ADDR_W    = 7,
    parameter int LOAD_CYC  = 16,
    parameter int DRAIN_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              tb_sel,
    output logic              i_cen,
    output logic              i_wen,
    output logic [ADDR_W-1:0] i_a,
    output logic              l0_wr,
    output logic              l0_rd,
    output logic              array_load,
    output logic              array_exec,
    input  logic              ofifo_valid,
    output logic              ofifo_rd,
    output logic [3:0]        kij_idx,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_W, S_LD_W, S_RD_A, S_EXEC, S_DRAIN
    } state_t;

    state_t              r_state, w_state_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic [3:0]          r_kij, w_kij_next;
    logic                r_cen, w_cen_next;
    logic [ADDR_W-1:0]   r_a, w_a_next;
    logic                r_l0_wr, w_l0_wr_next;
    logic                r_l0_rd, w_l0_rd_next;
    logic                r_load, w_load_next;
    logic                r_exec, w_exec_next;
    logic                r_busy, w_busy_next;
    logic                r_done, w_done_next;

    // Outputs are derived from the next state/count and registered, so they
    // line up with the cycle the FSM actually spends in that state/count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_kij   <= '0;
            r_cen   <= 1'b1;
            r_a     <= '0;
            r_l0_wr <= 1'b0;
            r_l0_rd <= 1'b0;
            r_load  <= 1'b0;
            r_exec  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_kij   <= w_kij_next;
            r_cen   <= w_cen_next;
            r_a     <= w_a_next;
            r_l0_wr <= w_l0_wr_next;
            r_l0_rd <= w_l0_rd_next;
            r_load  <= w_load_next;
            r_exec  <= w_exec_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_kij_next   = r_kij;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                w_kij_next = '0;
                if (start && !tb_sel) w_state_next = S_RD_W;
            end
            S_RD_W: if (r_cnt == CNT_W'(row - 1)) begin
                w_state_next = S_LD_W;
                w_cnt_next   = '0;
            end
            S_LD_W: if (r_cnt == CNT_W'(LOAD_CYC - 1)) begin
                w_state_next = S_RD_A;
                w_cnt_next   = '0;
            end
            S_RD_A: if (r_cnt == CNT_W'(len_nij - 1)) begin
                w_state_next = S_EXEC;
                w_cnt_next   = '0;
            end
            S_EXEC: if (r_cnt == CNT_W'(len_nij - 1)) begin
                w_state_next = S_DRAIN;
                w_cnt_next   = '0;
            end
            S_DRAIN: if (r_cnt == CNT_W'(DRAIN_CYC - 1)) begin
                w_cnt_next = '0;
                if (r_kij == 4'(len_kij - 1)) begin
                    w_state_next = S_IDLE;
                    w_kij_next   = '0;
                end else begin
                    w_state_next = S_RD_W;
                    w_kij_next   = r_kij + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase

        w_cen_next = !(w_state_next == S_RD_W || w_state_next == S_RD_A);
        w_a_next   = '0;
        if (w_state_next == S_RD_W)
            w_a_next = ADDR_W'(W_BASE + int'(w_kij_next) * row + int'(w_cnt_next));
        else if (w_state_next == S_RD_A)
            w_a_next = ADDR_W'(A_BASE + int'(w_cnt_next));

        // SRAM Q arrives one cycle after the read, so L0 writes trail the reads.
        w_l0_wr_next = (r_state == S_RD_W) || (r_state == S_RD_A);
        w_l0_rd_next = ((w_state_next == S_LD_W) && (w_cnt_next >= CNT_W'(1))
                            && (w_cnt_next <= CNT_W'(row)))
                    || ((w_state_next == S_EXEC) && (w_cnt_next >= CNT_W'(1)))
                    || ((w_state_next == S_DRAIN) && (w_cnt_next == '0));
        w_load_next  = (w_state_next == S_LD_W);
        w_exec_next  = (w_state_next == S_EXEC);
        w_busy_next  = (w_state_next != S_IDLE);
        w_done_next  = (r_state == S_DRAIN) && (w_state_next == S_IDLE);
    end

    assign i_cen      = r_cen;
    assign i_wen      = 1'b1;
    assign i_a        = r_a;
    assign l0_wr      = r_l0_wr;
    assign l0_rd      = r_l0_rd;
    assign array_load = r_load;
    assign array_exec = r_exec;
    assign kij_idx    = r_kij;
    assign busy       = r_busy;
    assign done       = r_done;
    assign ofifo_rd   = ofifo_valid & r_busy;
endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: captures one full layer trace and checks it
// against a table of hand-computed vectors, plus reset/idle/abort/FIFO sequences.
module tb_conv_sequencer;
    localparam int LAYER = 1008;
    localparam int TRACE = 1010;

    logic       clk = 1'b0;
    logic       reset, start, tb_sel, ofifo_valid;
    logic       i_cen, i_wen, l0_wr, l0_rd, array_load, array_exec, ofifo_rd, busy, done;
    logic [6:0] i_a;
    logic [3:0] kij_idx;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       cen;
        logic [6:0] a;
        logic       wr, rd, ld, ex;
        logic [3:0] kij;
        logic       bsy, dn;
    } obs_t;

    typedef struct {
        int   idx;
        obs_t exp;
    } vec_t;

    obs_t trace [TRACE];
    vec_t vecs[$];

    conv_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .tb_sel(tb_sel),
        .i_cen(i_cen), .i_wen(i_wen), .i_a(i_a), .l0_wr(l0_wr), .l0_rd(l0_rd),
        .array_load(array_load), .array_exec(array_exec),
        .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
        .kij_idx(kij_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("check %s: got %0d ok", name, act);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.cen = i_cen; o.a = i_a; o.wr = l0_wr; o.rd = l0_rd;
        o.ld = array_load; o.ex = array_exec; o.kij = kij_idx;
        o.bsy = busy; o.dn = done;
        return o;
    endfunction

    function automatic int pack(input obs_t o);
        return {o.cen, o.a, o.wr, o.rd, o.ld, o.ex, o.kij, o.bsy, o.dn};
    endfunction

    task automatic add(input int idx, input logic cen, input int a, input logic wr,
                       input logic rd, input logic ld, input logic ex, input int kij,
                       input logic bsy, input logic dn);
        vec_t v;
        v.idx = idx;
        v.exp = '{cen: cen, a: 7'(a), wr: wr, rd: rd, ld: ld, ex: ex,
                  kij: 4'(kij), bsy: bsy, dn: dn};
        vecs.push_back(v);
    endtask

    initial begin
        int fifo_bad, done_cnt, found;

        // Trace vectors: index 0 is the first RD_W cycle; kij k starts at 112*k.
        //   idx   cen  a   wr rd ld ex kij busy done
        add(0,    1'b0, 0,  0, 0, 0, 0, 0, 1, 0);
        add(7,    1'b0, 7,  1, 0, 0, 0, 0, 1, 0);
        add(8,    1'b1, 0,  1, 0, 1, 0, 0, 1, 0);
        add(9,    1'b1, 0,  0, 1, 1, 0, 0, 1, 0);
        add(16,   1'b1, 0,  0, 1, 1, 0, 0, 1, 0);
        add(17,   1'b1, 0,  0, 0, 1, 0, 0, 1, 0);
        add(23,   1'b1, 0,  0, 0, 1, 0, 0, 1, 0);
        add(24,   1'b0, 72, 0, 0, 0, 0, 0, 1, 0);
        add(25,   1'b0, 73, 1, 0, 0, 0, 0, 1, 0);
        add(59,   1'b0, 107,1, 0, 0, 0, 0, 1, 0);
        add(60,   1'b1, 0,  1, 0, 0, 1, 0, 1, 0);
        add(61,   1'b1, 0,  0, 1, 0, 1, 0, 1, 0);
        add(95,   1'b1, 0,  0, 1, 0, 1, 0, 1, 0);
        add(96,   1'b1, 0,  0, 1, 0, 0, 0, 1, 0);
        add(97,   1'b1, 0,  0, 0, 0, 0, 0, 1, 0);
        add(111,  1'b1, 0,  0, 0, 0, 0, 0, 1, 0);
        add(112,  1'b0, 8,  0, 0, 0, 0, 1, 1, 0);
        add(113,  1'b0, 9,  1, 0, 0, 0, 1, 1, 0);
        add(336,  1'b0, 24, 0, 0, 0, 0, 3, 1, 0);
        add(343,  1'b0, 31, 1, 0, 0, 0, 3, 1, 0);
        add(1007, 1'b1, 0,  0, 0, 0, 0, 8, 1, 0);
        add(1008, 1'b1, 0,  0, 0, 0, 0, 0, 0, 1);
        add(1009, 1'b1, 0,  0, 0, 0, 0, 0, 0, 0);

        reset = 1'b1; start = 1'b0; tb_sel = 1'b0; ofifo_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_cen", int'(i_cen), 1);
        check("reset_wen", int'(i_wen), 1);
        check("reset_addr", int'(i_a), 0);
        check("reset_busy_done", int'({busy, done, l0_wr, l0_rd, array_load, array_exec}), 0);
        reset = 1'b0;

        start = 1'b1; tb_sel = 1'b1;
        repeat (3) @(negedge clk);
        check("tbsel_blocks_start", int'({busy, i_cen}), 1);
        start = 1'b0; tb_sel = 1'b0;

        // Full layer capture with random FIFO activity.
        @(negedge clk);
        start = 1'b1;
        fifo_bad = 0;
        for (int i = 0; i < TRACE; i++) begin
            @(negedge clk);
            start = 1'b0;
            trace[i] = sample();
            ofifo_valid = 1'($urandom_range(0, 1));
            #1;
            if (ofifo_rd !== (ofifo_valid & (i < LAYER))) fifo_bad++;
        end
        check("ofifo_rd_mirror_bad", fifo_bad, 0);

        foreach (vecs[n]) begin
            check($sformatf("vec_idx%0d", vecs[n].idx),
                  pack(trace[vecs[n].idx]), pack(vecs[n].exp));
        end

        done_cnt = 0;
        for (int i = 0; i < TRACE; i++) if (trace[i].dn) done_cnt++;
        check("done_pulses", done_cnt, 1);

        for (int k = 0; k < 9; k++) begin
            int nld, nex, nwr, nrd, bad_w, bad_a;
            nld = 0; nex = 0; nwr = 0; nrd = 0; bad_w = 0; bad_a = 0;
            for (int c = 0; c < 112; c++) begin
                nld += int'(trace[k*112+c].ld);
                nex += int'(trace[k*112+c].ex);
                nwr += int'(trace[k*112+c].wr);
                nrd += int'(trace[k*112+c].rd);
            end
            for (int c = 0; c < 8; c++)
                if (trace[k*112+c].cen !== 1'b0 || int'(trace[k*112+c].a) != 8*k + c) bad_w++;
            for (int c = 0; c < 36; c++)
                if (trace[k*112+24+c].cen !== 1'b0 || int'(trace[k*112+24+c].a) != 72 + c) bad_a++;
            check($sformatf("kij%0d_counts", k), (nld << 24) | (nex << 16) | (nwr << 8) | nrd,
                  (16 << 24) | (36 << 16) | (44 << 8) | 44);
            check($sformatf("kij%0d_addr_bad", k), bad_w + bad_a, 0);
        end

        ofifo_valid = 1'b1;
        #1;
        check("ofifo_rd_idle", int'(ofifo_rd), 0);
        ofifo_valid = 1'b0;

        // Abort in EXEC at kij=5.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int t = 0; t < 2000 && found == 0; t++) begin
            if (kij_idx == 4'd5 && array_exec) found = 1;
            else @(negedge clk);
        end
        check("reach_kij5_exec", found, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_state", int'({busy, i_cen, done, kij_idx, array_exec}), 8'b0_1_0_0000_0);
        done_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || !i_cen) done_cnt++;
        end
        check("abort_quiet", done_cnt, 0);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_first_read", int'({i_cen, i_a, kij_idx, busy}), int'({1'b0, 7'd0, 4'd0, 1'b1}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
